// File: rtl/up_sign_rx_pkg.sv
// ============================================================================
// Module  : up_sign_rx_pkg
// Brief   : Shared frame constants and FSM encodings for the upstream status receiver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package up_sign_rx_pkg;

  localparam logic [7:0] c_SOF       = 8'hA5;
  localparam int         c_FRAME_LEN = 16;
  localparam logic [3:0] c_IDX_FIRST = 4'd1;
  localparam logic [3:0] c_IDX_CRC   = 4'(c_FRAME_LEN - 1);
  localparam int         c_SHADOW_W  = 8 * (c_FRAME_LEN - 2);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    FR_HUNT    = 2'd0,
    FR_PAYLOAD = 2'd1,
    FR_CHECK   = 2'd2
  } frm_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_byte_rx.sv
// ============================================================================
// Module  : uart_byte_rx
// Brief   : 2-FF synchroniser plus 8N1 UART byte receiver with mid-bit sampling.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_rx
  import up_sign_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       byte_ferr
);

  localparam int                 c_CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t          r_state;
  rx_state_t          w_state_nxt;
  logic               r_rxd_meta;
  logic               r_rxd_sync;
  logic               r_rxd_prev;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_byte_vld;
  logic               r_byte_ferr;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= RX_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RX_IDLE:  if (r_rxd_prev && !r_rxd_sync) w_state_nxt = RX_START;
      RX_START: if (r_cnt == c_HALF) w_state_nxt = r_rxd_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (r_cnt == c_FULL && r_bit_idx == 3'd7) w_state_nxt = RX_STOP;
      RX_STOP:  if (r_cnt == c_FULL) w_state_nxt = RX_IDLE;
      default:  w_state_nxt = RX_IDLE;
    endcase
  end

  // After the half-bit start check every later sample lands one full bit on.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rxd_meta  <= 1'b1;
      r_rxd_sync  <= 1'b1;
      r_rxd_prev  <= 1'b1;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_byte_vld  <= 1'b0;
      r_byte_ferr <= 1'b0;
    end else begin
      r_rxd_meta  <= rxd;
      r_rxd_sync  <= r_rxd_meta;
      r_rxd_prev  <= r_rxd_sync;
      r_byte_vld  <= 1'b0;
      r_byte_ferr <= 1'b0;

      if (r_state == RX_IDLE || r_cnt == c_FULL || (r_state == RX_START && r_cnt == c_HALF))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;

      if (r_state == RX_START) r_bit_idx <= '0;

      if (r_state == RX_DATA && r_cnt == c_FULL) begin
        r_shift   <= {r_rxd_sync, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      if (r_state == RX_STOP && r_cnt == c_FULL) begin
        r_byte_vld  <= r_rxd_sync;
        r_byte_ferr <= !r_rxd_sync;
      end
    end
  end

  assign rx_byte   = r_shift;
  assign byte_vld  = r_byte_vld;
  assign byte_ferr = r_byte_ferr;

endmodule

`default_nettype wire

// File: rtl/up_sign_rx.sv
// ============================================================================
// Module  : up_sign_rx
// Brief   : Upstream power-unit status frame receiver; optional link watchdog
//           enabled by defining UP_LINK_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module up_sign_rx
  import up_sign_rx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          GAP_CLKS     = 20 * 434,
  parameter logic [15:0] EXP_VER      = 16'h3011,
  parameter int          TIMEOUT_CLKS = 5_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rxd,
  output logic        fault,
  output logic        rect_over,
  output logic [15:0] state,
  output logic [11:0] volt,
  output logic [15:0] fre_data,
  output logic [12:0] t_data,
  output logic [19:0] rect_data,
  output logic [15:0] ver,
  output logic        ver_mismatch,
  output logic        frame_ok,
  output logic        crc_err,
  output logic        fmt_err,
  output logic        link_lost
);

  localparam int                 c_GAP_W   = $clog2(GAP_CLKS + 2);
  localparam logic [c_GAP_W-1:0] c_GAP_MAX = c_GAP_W'(GAP_CLKS);

  logic [7:0]            w_rx_byte;
  logic                  w_byte_vld;
  logic                  w_byte_ferr;
  frm_state_t            r_frm;
  frm_state_t            w_frm_nxt;
  logic                  w_latch;
  logic                  w_crc_bad;
  logic                  w_fmt_bad;
  logic [3:0]            r_idx;
  logic [7:0]            r_sum;
  logic [c_GAP_W-1:0]    r_gap;
  logic [c_SHADOW_W-1:0] r_shadow;
  logic                  r_fault;
  logic                  r_rect_over;
  logic [15:0]           r_state_word;
  logic [11:0]           r_volt;
  logic [15:0]           r_fre;
  logic [12:0]           r_t;
  logic [19:0]           r_rect;
  logic [15:0]           r_ver;
  logic                  r_ver_mismatch;
  logic                  r_frame_ok;
  logic                  r_crc_err;
  logic                  r_fmt_err;
  logic                  r_link_lost;
  logic                  w_unused_rsvd;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
    .clk       (clk),
    .rstn      (rstn),
    .rxd       (rxd),
    .rx_byte   (w_rx_byte),
    .byte_vld  (w_byte_vld),
    .byte_ferr (w_byte_ferr)
  );

  always_ff @(posedge clk) begin
    if (!rstn) r_frm <= FR_HUNT;
    else       r_frm <= w_frm_nxt;
  end

  // The checksum compare happens on B15 arrival so the pulse and the new
  // field values appear together one clock after the stop-bit sample.
  always_comb begin
    w_frm_nxt = r_frm;
    w_latch   = 1'b0;
    w_crc_bad = 1'b0;
    w_fmt_bad = 1'b0;
    unique case (r_frm)
      FR_HUNT: if (w_byte_vld && w_rx_byte == c_SOF) w_frm_nxt = FR_PAYLOAD;
      FR_PAYLOAD: begin
        if (w_byte_ferr || r_gap > c_GAP_MAX) begin
          w_fmt_bad = 1'b1;
          w_frm_nxt = FR_HUNT;
        end else if (w_byte_vld && r_idx == c_IDX_CRC) begin
          w_frm_nxt = FR_CHECK;
          w_latch   = (r_sum == w_rx_byte);
          w_crc_bad = (r_sum != w_rx_byte);
        end
      end
      FR_CHECK: w_frm_nxt = FR_HUNT;
      default:  w_frm_nxt = FR_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_idx          <= '0;
      r_sum          <= '0;
      r_gap          <= '0;
      r_shadow       <= '0;
      r_fault        <= 1'b0;
      r_rect_over    <= 1'b0;
      r_state_word   <= '0;
      r_volt         <= '0;
      r_fre          <= '0;
      r_t            <= '0;
      r_rect         <= '0;
      r_ver          <= '0;
      r_ver_mismatch <= 1'b0;
      r_frame_ok     <= 1'b0;
      r_crc_err      <= 1'b0;
      r_fmt_err      <= 1'b0;
    end else begin
      r_frame_ok <= w_latch;
      r_crc_err  <= w_crc_bad;
      r_fmt_err  <= w_fmt_bad;

      if (r_frm == FR_HUNT && w_frm_nxt == FR_PAYLOAD) begin
        r_idx <= c_IDX_FIRST;
        r_sum <= '0;
      end else if (r_frm == FR_PAYLOAD && w_frm_nxt == FR_PAYLOAD && w_byte_vld) begin
        r_shadow <= {r_shadow[c_SHADOW_W-9:0], w_rx_byte};
        r_sum    <= r_sum + w_rx_byte;
        r_idx    <= r_idx + 1'b1;
      end

      if (r_frm == FR_PAYLOAD && !w_byte_vld) r_gap <= r_gap + 1'b1;
      else                                    r_gap <= '0;

      // Shadow holds B1 in the top byte down to B14 in the bottom byte.
      if (w_latch) begin
        r_fault        <= r_shadow[104];
        r_rect_over    <= r_shadow[105];
        r_state_word   <= r_shadow[103:88];
        r_volt         <= r_shadow[83:72];
        r_fre          <= r_shadow[71:56];
        r_t            <= r_shadow[52:40];
        if (r_shadow[105]) r_rect <= r_shadow[35:16];
        r_ver          <= r_shadow[15:0];
        r_ver_mismatch <= (r_shadow[15:0] != EXP_VER);
      end
    end
  end

  assign w_unused_rsvd = ^{r_shadow[111:106], r_shadow[87:84], r_shadow[55:53], r_shadow[39:36]};

`ifdef UP_LINK_TIMEOUT_EN
  localparam int                c_WD_W   = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT_CLKS - 1);

  logic [c_WD_W-1:0] r_wd;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wd        <= '0;
      r_link_lost <= 1'b1;
    end else if (w_latch) begin
      r_wd        <= '0;
      r_link_lost <= 1'b0;
    end else if (r_wd == c_WD_MAX) begin
      r_link_lost <= 1'b1;
    end else begin
      r_wd <= r_wd + 1'b1;
    end
  end

  assign fault = r_fault | r_link_lost;
`else
  logic w_unused_timeout;

  always_ff @(posedge clk) begin
    if (!rstn)        r_link_lost <= 1'b1;
    else if (w_latch) r_link_lost <= 1'b0;
  end

  assign w_unused_timeout = (TIMEOUT_CLKS == 0);
  assign fault            = r_fault;
`endif

  assign rect_over    = r_rect_over;
  assign state        = r_state_word;
  assign volt         = r_volt;
  assign fre_data     = r_fre;
  assign t_data       = r_t;
  assign rect_data    = r_rect;
  assign ver          = r_ver;
  assign ver_mismatch = r_ver_mismatch;
  assign frame_ok     = r_frame_ok;
  assign crc_err      = r_crc_err;
  assign fmt_err      = r_fmt_err;
  assign link_lost    = r_link_lost;

endmodule

`default_nettype wire

// File: tb/tb_up_sign_rx.sv
// ============================================================================
// Module  : tb_up_sign_rx
// Brief   : Directed self-checking bench for up_sign_rx (UP_LINK_TIMEOUT_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_up_sign_rx;

  localparam int CPB = 16;
  localparam int GAP = 20 * CPB;
  localparam int TO  = 4000;
`ifdef UP_LINK_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rxd = 1'b1;
  logic        fault, rect_over, ver_mismatch, frame_ok, crc_err, fmt_err, link_lost;
  logic [15:0] state, fre_data, ver;
  logic [11:0] volt;
  logic [12:0] t_data;
  logic [19:0] rect_data;

  up_sign_rx #(.CLKS_PER_BIT(CPB), .GAP_CLKS(GAP), .EXP_VER(16'h3011), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .fault(fault), .rect_over(rect_over),
    .state(state), .volt(volt), .fre_data(fre_data), .t_data(t_data),
    .rect_data(rect_data), .ver(ver), .ver_mismatch(ver_mismatch),
    .frame_ok(frame_ok), .crc_err(crc_err), .fmt_err(fmt_err), .link_lost(link_lost)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_ok = 0, n_crc = 0, n_fmt = 0, n_bytes = 0;
  int saved;
  logic [7:0] fr [16];

  always @(negedge clk) begin
    if (frame_ok) n_ok++;
    if (crc_err) n_crc++;
    if (fmt_err) n_fmt++;
    if (dut.u_byte_rx.byte_vld) n_bytes++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int clks);
    repeat (clks) @(negedge clk);
  endtask

  task automatic build(input logic f, input logic ro, input logic [15:0] st,
                       input logic [11:0] v, input logic [15:0] fq, input logic [12:0] t,
                       input logic [19:0] rd, input logic [15:0] vr);
    logic [7:0] sum;
    fr[0]  = 8'hA5;
    fr[1]  = {6'b0, ro, f};
    fr[2]  = st[15:8];           fr[3]  = st[7:0];
    fr[4]  = {4'b0, v[11:8]};    fr[5]  = v[7:0];
    fr[6]  = fq[15:8];           fr[7]  = fq[7:0];
    fr[8]  = {3'b0, t[12:8]};    fr[9]  = t[7:0];
    fr[10] = {4'b0, rd[19:16]};  fr[11] = rd[15:8];  fr[12] = rd[7:0];
    fr[13] = vr[15:8];           fr[14] = vr[7:0];
    sum = 8'h00;
    for (int i = 1; i <= 14; i++) sum = sum + fr[i];
    fr[15] = sum;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = stop;
    idle(CPB);
    rxd = 1'b1;
  endtask

  task automatic send_frame(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(fr[i], 1'b1);
    idle(2 * CPB);
  endtask

  initial begin
    idle(4);
    check("rst_fault", fault, WD);
    check("rst_state", state, 16'h0);
    check("rst_rect", rect_data, 20'h0);
    check("rst_ver", ver, 16'h0);
    check("rst_verm", ver_mismatch, 1'b0);
    check("rst_link", link_lost, 1'b1);
    rstn = 1'b1;
    idle(3 * CPB);

    // Good frame
    build(1'b1, 1'b1, 16'h0123, 12'hABC, 16'h1F40, 13'h0155, 20'hABCDE, 16'h3011);
    send_frame(0, 15);
    check("a_ok_cnt", n_ok, 1);
    check("a_fault", fault, 1'b1);
    check("a_rect_over", rect_over, 1'b1);
    check("a_state", state, 16'h0123);
    check("a_volt", volt, 12'hABC);
    check("a_fre", fre_data, 16'h1F40);
    check("a_t", t_data, 13'h0155);
    check("a_rect", rect_data, 20'hABCDE);
    check("a_ver", ver, 16'h3011);
    check("a_verm", ver_mismatch, 1'b0);
    check("a_link", link_lost, 1'b0);

    // Checksum off by one
    build(1'b1, 1'b1, 16'h7777, 12'hABC, 16'h1F40, 13'h0155, 20'hABCDE, 16'h3011);
    fr[15] = fr[15] + 8'h01;
    send_frame(0, 15);
    check("crc_cnt", n_crc, 1);
    check("crc_ok_cnt", n_ok, 1);
    check("crc_state", state, 16'h0123);

    // Noise then a frame with rect_over=0
    send_byte(8'h00, 1'b1);
    send_byte(8'h5A, 1'b1);
    build(1'b0, 1'b0, 16'h4567, 12'h123, 16'h0032, 13'h1FFF, 20'h12345, 16'h3011);
    send_frame(0, 15);
    check("b_ok_cnt", n_ok, 2);
    check("b_fault", fault, 1'b0);
    check("b_rect_over", rect_over, 1'b0);
    check("b_state", state, 16'h4567);
    check("b_volt", volt, 12'h123);
    check("b_t", t_data, 13'h1FFF);
    check("b_rect_kept", rect_data, 20'hABCDE);

    // Bad stop bit on B7
    send_frame(0, 6);
    send_byte(fr[7], 1'b0);
    idle(4 * CPB);
    check("ferr_cnt", n_fmt, 1);
    send_frame(0, 15);
    check("ferr_recover", n_ok, 3);

    // Stall after B9
    send_frame(0, 9);
    idle(30 * CPB);
    check("gap_cnt", n_fmt, 2);
    check("gap_no_ok", n_ok, 3);
    send_frame(0, 15);
    check("gap_recover", n_ok, 4);
    check("crc_cnt_end", n_crc, 1);

    // Version mismatch
    build(1'b0, 1'b1, 16'h0BEE, 12'h7FF, 16'h0001, 13'h0002, 20'hFEDCB, 16'h3012);
    send_frame(0, 15);
    check("v_ok_cnt", n_ok, 5);
    check("v_ver", ver, 16'h3012);
    check("v_verm", ver_mismatch, 1'b1);
    check("v_rect", rect_data, 20'hFEDCB);

    // Quarter-bit glitch on idle line
    saved = n_bytes;
    rxd = 1'b0;
    idle(CPB / 4);
    rxd = 1'b1;
    idle(12 * CPB);
    check("glitch_bytes", n_bytes, saved);

    // Reset in the middle of a frame
    build(1'b0, 1'b1, 16'h1111, 12'h222, 16'h3333, 13'h0444, 20'h55555, 16'h3011);
    send_frame(0, 7);
    rstn = 1'b0;
    idle(3);
    check("mr_state", state, 16'h0);
    check("mr_ver", ver, 16'h0);
    check("mr_verm", ver_mismatch, 1'b0);
    check("mr_link", link_lost, 1'b1);
    check("mr_fault", fault, WD);
    rstn = 1'b1;
    saved = n_ok;
    send_frame(8, 15);
    check("mr_no_ok", n_ok, saved);
    check("mr_state2", state, 16'h0);
    send_frame(0, 15);
    check("mr_recover", n_ok, saved + 1);
    check("mr_rect", rect_data, 20'h55555);
    check("mr_link2", link_lost, 1'b0);

`ifdef UP_LINK_TIMEOUT_EN
    idle(TO + 50);
    check("wd_link", link_lost, 1'b1);
    check("wd_fault", fault, 1'b1);
    send_frame(0, 15);
    check("wd_link_clr", link_lost, 1'b0);
    check("wd_fault_clr", fault, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
